// File: rtl/iterative_divider_if.sv
// iterative_divider_if: request/response bundle between the execute stage and the divider
interface iterative_divider_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, op, dividend, divisor, flush, input busy, done, result);
  modport slave(input start, op, dividend, divisor, flush, output busy, done, result);
endinterface

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle RV32M DIV/DIVU/REM/REMU, restoring shift-subtract, one bit per cycle
module iterative_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  iterative_divider_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   dd, dv, rem, q, dmag, result_r;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r, busy_r, done_r;
  logic              sgn, sd, sv;
  logic [XLEN-1:0]   dd_mag, dv_mag, qf, rf;
  logic [XLEN:0]     diff;
  assign sgn    = ~op_r[0];
  assign sd     = sgn & dd[XLEN-1];
  assign sv     = sgn & dv[XLEN-1];
  assign dd_mag = sd ? -dd : dd;
  assign dv_mag = sv ? -dv : dv;
  // 33-bit trial subtraction keeps divisors >= 2^31 correct for unsigned ops
  assign diff   = {rem, q[XLEN-1]} - {1'b0, dmag};
  assign qf     = neg_q ? -q : q;
  assign rf     = neg_r ? -rem : rem;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r   <= bus.op;
          dd     <= bus.dividend;
          dv     <= bus.divisor;
          busy_r <= 1'b1;
          state  <= SETUP;
        end
        SETUP: if (dv == '0 || (sgn && dd == MIN && dv == '1)) begin
          result_r <= dv == '0 ? (op_r[1] ? dd : '1) : (op_r[1] ? '0 : MIN);
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= DONE;
        end else begin
          rem   <= '0;
          q     <= dd_mag;
          dmag  <= dv_mag;
          neg_q <= sd ^ sv;
          neg_r <= sd;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          rem   <= diff[XLEN] ? {rem[XLEN-2:0], q[XLEN-1]} : diff[XLEN-1:0];
          q     <= {q[XLEN-2:0], ~diff[XLEN]};
          cnt   <= cnt + CNT_W'(1);
          state <= cnt == CNT_W'(XLEN-1) ? FIXUP : ITER;
        end
        FIXUP: begin
          result_r <= op_r[1] ? rf : qf;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed vectors with hand-computed quotients, remainders and latencies
module tb_iterative_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last = '0;
  iterative_divider_if bus();
  iterative_divider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc);
    int cyc;
    int busy_bad;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.dividend = 32'h0; bus.divisor = 32'h0;
    cyc = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.done && !bus.busy) busy_bad++;
    end while (!bus.done && cyc < 50);
    check({tag, " cycle"}, cyc, exp_cyc);
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy@done"}, {31'b0, bus.busy}, 32'd0);
    check({tag, " busy gaps"}, busy_bad, 0);
    @(negedge clk);
    check({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    last = exp;
  endtask
  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    reset = 1'b0;
    run_op("divu 100/7", 2'd1, 32'd100, 32'd7, 32'd14, 35);
    run_op("remu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 35);
    run_op("div -7/2", 2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
    run_op("rem -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35);
    run_op("rem 7/-2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 35);
    run_op("div 100/-7", 2'd0, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 35);
    run_op("divu 5/0", 2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 2);
    run_op("remu 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 2);
    run_op("rem min/0", 2'd2, 32'h80000000, 32'd0, 32'h80000000, 2);
    run_op("div ovf", 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
    run_op("divu ovf ops", 2'd1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 35);
    run_op("divu max/2^31", 2'd1, 32'hFFFFFFFF, 32'h80000000, 32'd1, 35);
    run_op("remu max/2^31", 2'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 35);
    // start held through DONE: operands change after cycle 0 and must not leak into the first op
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.dividend = 32'hFFFFFFFF; bus.divisor = 32'h80000000;
    @(posedge clk);
    #1 bus.op = 2'd3; bus.divisor = 32'd0;
    repeat (35) @(negedge clk);
    check("b2b first done", {31'b0, bus.done}, 32'd1);
    check("b2b first result", bus.result, 32'd1);
    @(negedge clk);
    check("b2b idle busy", {31'b0, bus.busy}, 32'd0);
    check("b2b idle done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    check("b2b accept busy", {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b second done", {31'b0, bus.done}, 32'd1);
    check("b2b second result", bus.result, 32'hFFFFFFFF);
    last = 32'hFFFFFFFF;
    @(negedge clk);
    // flush at cycle 10
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-flush busy", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush result", bus.result, last);
    begin
      int dones = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      check("flush no done", dones, 0);
    end
    check("flush result held", bus.result, last);
    // flush and start together in IDLE: start dropped
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start busy", {31'b0, bus.busy}, 32'd0);
    run_op("divu after flush", 2'd1, 32'd1000, 32'd3, 32'd333, 35);
    // reset at cycle 20
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset mid busy", {31'b0, bus.busy}, 32'd0);
    check("reset mid done", {31'b0, bus.done}, 32'd0);
    check("reset mid result", bus.result, 32'd0);
    begin
      int dones = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      check("reset no done", dones, 0);
    end
    run_op("remu after reset", 2'd3, 32'd1000, 32'd3, 32'd1, 35);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
